// File: rtl/ov7670_config_seq.sv
// ov7670_config_seq: walks the OV7670 configuration ROM and issues one SCCB register
// write per entry. FFF0 entries insert a delay, FFFF ends the table.
// Optional feature macro: CFG_NACK_RETRY_EN (retry a NACKed write up to MAX_RETRY times).
module ov7670_config_seq #(
    parameter int unsigned DELAY_CYCLES = 250_000,
    parameter int unsigned ADDR_W       = 5,
    parameter logic [7:0]  SCCB_ID      = 8'h42,
    parameter int unsigned MAX_RETRY    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_valid,
    input  logic              sccb_ready,
    output logic [7:0]        sccb_id,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_wdata,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              busy,
    output logic              cfg_done,
    output logic              err
);

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StSend,
        StWaitDone,
        StDelay,
        StDone
    } state_e;

    localparam logic [15:0]       MarkEnd   = 16'hFFFF;
    localparam logic [15:0]       MarkDelay = 16'hFFF0;
    localparam logic [ADDR_W-1:0] LastAddr  = '1;
    localparam int unsigned       CntW      = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
    localparam logic [CntW-1:0]   DelayLoad = CntW'(DELAY_CYCLES - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        sccb_reg_q, sccb_reg_d;
    logic [7:0]        sccb_wdata_q, sccb_wdata_d;
    logic              err_q, err_d;
    logic [CntW-1:0]   delay_cnt_q, delay_cnt_d;
    logic              advance;

`ifdef CFG_NACK_RETRY_EN
    localparam int unsigned     RetryW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);

    logic [RetryW-1:0] retry_cnt_q, retry_cnt_d;

    // Retry counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_cnt_q <= '0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
        end
    end
`else
    // Retry limit has no meaning without the retry feature.
    logic unused_max_retry;
    assign unused_max_retry = ^MAX_RETRY;
`endif

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StFetch;
            rom_addr_q   <= '0;
            sccb_reg_q   <= '0;
            sccb_wdata_q <= '0;
            err_q        <= 1'b0;
            delay_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            rom_addr_q   <= rom_addr_d;
            sccb_reg_q   <= sccb_reg_d;
            sccb_wdata_q <= sccb_wdata_d;
            err_q        <= err_d;
            delay_cnt_q  <= delay_cnt_d;
        end
    end

    // Next-state logic; 'advance' funnels every entry completion through one place.
    always_comb begin
        state_d      = state_q;
        rom_addr_d   = rom_addr_q;
        sccb_reg_d   = sccb_reg_q;
        sccb_wdata_d = sccb_wdata_q;
        err_d        = err_q;
        delay_cnt_d  = delay_cnt_q;
        advance      = 1'b0;
`ifdef CFG_NACK_RETRY_EN
        retry_cnt_d  = retry_cnt_q;
`endif

        unique case (state_q)
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                if (rom_data == MarkEnd) begin
                    state_d = StDone;
                end else if (rom_data == MarkDelay) begin
                    state_d     = StDelay;
                    delay_cnt_d = DelayLoad;
                end else begin
                    sccb_reg_d   = rom_data[15:8];
                    sccb_wdata_d = rom_data[7:0];
                    state_d      = StSend;
                end
            end
            StSend: begin
                if (sccb_ready) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (sccb_done) begin
                    if (sccb_nack) begin
`ifdef CFG_NACK_RETRY_EN
                        if (retry_cnt_q == RetryMax) begin
                            err_d   = 1'b1;
                            advance = 1'b1;
                        end else begin
                            retry_cnt_d = retry_cnt_q + RetryW'(1);
                            state_d     = StSend;
                        end
`else
                        err_d   = 1'b1;
                        advance = 1'b1;
`endif
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StDelay: begin
                if (delay_cnt_q == '0) begin
                    advance = 1'b1;
                end else begin
                    delay_cnt_d = delay_cnt_q - CntW'(1);
                end
            end
            StDone: begin
                if (start) begin
                    rom_addr_d = '0;
                    err_d      = 1'b0;
                    state_d    = StFetch;
                end
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // The last table slot ends the sequence instead of wrapping to 0.
        if (advance) begin
`ifdef CFG_NACK_RETRY_EN
            retry_cnt_d = '0;
`endif
            if (rom_addr_q == LastAddr) begin
                state_d = StDone;
            end else begin
                rom_addr_d = rom_addr_q + ADDR_W'(1);
                state_d    = StFetch;
            end
        end
    end

    assign rom_addr   = rom_addr_q;
    assign sccb_valid = (state_q == StSend);
    assign sccb_id    = SCCB_ID;
    assign sccb_reg   = sccb_reg_q;
    assign sccb_wdata = sccb_wdata_q;
    assign busy       = (state_q != StDone);
    assign cfg_done   = (state_q == StDone);
    assign err        = err_q;

endmodule

// File: doc/ov7670_config_seq.md
# ov7670_config_seq

Walks the OV7670 register-configuration ROM from address 0 and turns each 16-bit entry into one SCCB register write. It sits between the config ROM (registered, one-cycle read latency) and the SCCB master. It interprets the ROM markers FFF0 (delay) and FFFF (end of table). It raises `cfg_done` when the camera is configured.

## Interface
Parameters:
- `DELAY_CYCLES`, 250_000 — clocks spent on an FFF0 entry (10 ms at 25 MHz)
- `ADDR_W`, 5 — ROM address width; table depth is 2**ADDR_W
- `SCCB_ID`, 8'h42 — OV7670 write device ID driven on `sccb_id`
- `MAX_RETRY`, 3 — retries per entry (used only with `CFG_NACK_RETRY_EN`)

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1 — system clock
- `reset` in 1 — async active-high reset
- `start` in 1 — one-cycle pulse; restarts the sequence from address 0 when in DONE
- `rom_addr` out ADDR_W — ROM address, registered
- `rom_data` in 16 — ROM output `{reg[15:8], value[7:0]}`, valid one clock after `rom_addr` changes
- `sccb_valid` out 1 — write request
- `sccb_ready` in 1 — master accepts the request on a rising edge where `sccb_valid & sccb_ready`
- `sccb_id` out 8 — constant `SCCB_ID`
- `sccb_reg` out 8 — register address
- `sccb_wdata` out 8 — register value
- `sccb_done` in 1 — one-cycle pulse when the accepted write finishes
- `sccb_nack` in 1 — qualified by `sccb_done`; 1 means the camera did not acknowledge
- `busy` out 1 — high in every state except DONE
- `cfg_done` out 1 — high in DONE
- `err` out 1 — sticky; cleared by `reset` or `start`

## Operation
States: FETCH, DECODE, SEND, WAIT_DONE, DELAY, DONE.

- **FETCH**: one cycle waiting for ROM latency; then → DECODE.
- **DECODE**: samples `rom_data`.
  - FFFF → DONE.
  - FFF0 → DELAY, with the counter loaded to `DELAY_CYCLES-1`.
  - Otherwise, latch `sccb_reg`/`sccb_wdata` from `rom_data` → SEND.
- **SEND**: `sccb_valid`=1. `sccb_reg`, `sccb_wdata` and `sccb_id` are held stable until the handshake. On handshake → WAIT_DONE, and `sccb_valid` drops the next cycle.
- **WAIT_DONE**: waits for `sccb_done`, then advances.
- **DELAY**: counts down to 0, then advances.
- **Advance**: if `rom_addr` == 2**ADDR_W−1, → DONE (no wrap). Otherwise `rom_addr`+1 → FETCH.
- **DONE**: `cfg_done`=1 and `rom_addr` is held. `start` sets `rom_addr`=0, clears `err`, → FETCH.
- `start` in any state other than DONE is ignored.
- An `sccb_done` outside WAIT_DONE is ignored.
- `sccb_done` with `sccb_nack`=1: behaviour is set by the macro below.

## Timing
- **Reset values**: state=FETCH, `rom_addr`=0, `sccb_valid`=0, `sccb_reg`=0, `sccb_wdata`=0, `busy`=1, `cfg_done`=0, `err`=0, delay counter=0, retry counter=0.
- The sequence starts automatically on reset release.
- **Startup latency**: cycle 0 (first edge after reset) FETCH, cycle 1 DECODE, cycle 2 `sccb_valid`=1.
- **Entry-to-entry latency**: `sccb_done` edge → FETCH, then 2 cycles to the next `sccb_valid`.
- **Delay entry**: DELAY occupies exactly `DELAY_CYCLES` cycles. Total time from DECODE of FFF0 to the next FETCH is `DELAY_CYCLES`+1.
- **Handshake**: `sccb_valid` never drops before acceptance. If `sccb_ready` is already 1 on the first SEND cycle, accept in that cycle.
- **Reset mid-operation**: asynchronous return to the reset values. A pending SCCB request is abandoned; the master must tolerate this.
- **`cfg_done`**: rises the cycle after DECODE of FFFF.

## Configuration
Macro: `CFG_NACK_RETRY_EN`.

- **Defined**: on a NACK, return to SEND with the same `sccb_reg`/`sccb_wdata` and increment the retry counter.
  - After `MAX_RETRY` failed retries, set `err` and advance.
  - The retry counter clears on every advance.
- **Undefined**: a NACK sets `err` and the sequencer advances immediately. `MAX_RETRY` is unused and there is no retry counter.

## Test plan
- **Normal table**: ROM model with 12 80, FFF0, 3A 04, FFFF; always ready, ACK, `DELAY_CYCLES`=8.
  - Expect writes (12,80) then (3A,04).
  - Expect exactly 8 DELAY cycles between them.
  - Expect `cfg_done`=1 with `rom_addr`=3.
- **Back-pressure**: `sccb_ready` held low for 5 cycles → `sccb_valid` is high for 6 cycles, and `sccb_reg`/`sccb_wdata` do not change.
- **NACK on entry 3A 04**:
  - With the macro: 1 + 3 attempts of (3A,04), then `err`=1 and the sequence continues.
  - Without the macro: one attempt, `err`=1, and the next entry follows.
- **Full table, no FFFF**: 32 valid entries → 32 writes, then DONE with `rom_addr`=31 and no wrap.
- **Reset mid-operation**: reset asserted during WAIT_DONE of entry 5 → outputs return to reset values; after release, entry 0 is re-issued at cycle 2.
- **Restart**: `start` pulse in DONE → `err`=0, `cfg_done`=0, and the table replays from address 0. A `start` pulse while `busy` has no effect.
